// File: rtl/wb_commit_unit.sv
`timescale 1ns/1ps
// wb_commit_unit: write-back commit FIFO feeding the register-file write port.
// Accepts load (mem) and ALU (exe) results, retires one per cycle in order,
// diverts R15 writes to a PC redirect, and reports pending writes to decode.
// Optional feature macro: WB_BYPASS_EN (forward youngest pending data to decode
// instead of flagging a hazard).
module wb_commit_unit #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exeValid,
    input  logic [3:0]                   exeRd,
    input  logic [N-1:0]                 exeResult,
    output logic                         exeReady,
    input  logic                         memValid,
    input  logic [3:0]                   memRd,
    input  logic [N-1:0]                 memData,
    output logic                         memReady,
    output logic                         regWrite,
    output logic [3:0]                   A3,
    output logic [N-1:0]                 WD3,
    output logic                         pcWrite,
    output logic [N-1:0]                 pcTarget,
    input  logic [3:0]                   A1,
    input  logic [3:0]                   A2,
    output logic                         hazA1,
    output logic                         hazA2,
    output logic                         fwdA1Valid,
    output logic                         fwdA2Valid,
    output logic [N-1:0]                 fwdA1Data,
    output logic [N-1:0]                 fwdA2Data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam logic [3:0]  PC_REG = 4'd15;

    typedef struct packed {
        logic [3:0]   rd;
        logic [N-1:0] data;
    } entry_t;

    entry_t          slot_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            mem_acc, exe_acc, deq;
    logic [PW-1:0]   exe_slot;
    entry_t          head_entry;
    logic            head_is_pc;

    logic            hit1, hit2;
    logic [PW-1:0]   look_idx;
`ifdef WB_BYPASS_EN
    logic [N-1:0]    fwd1, fwd2;
`endif

    // Acceptance depends only on registered occupancy; exe needs room behind mem.
    always_comb begin
        memReady = !reset && (count_q <= CW'(DEPTH - 1));
        exeReady = !reset && (count_q <= CW'(DEPTH - 2));
        mem_acc  = memValid && memReady;
        exe_acc  = exeValid && exeReady;
        deq      = (count_q != '0);
    end

    // Pointer and occupancy bookkeeping; mem lands at tail, exe right behind it.
    always_comb begin
        exe_slot = tail_q + PW'(mem_acc);
        tail_d   = tail_q + PW'(mem_acc) + PW'(exe_acc);
        head_d   = head_q + PW'(deq);
        count_d  = count_q + CW'(mem_acc) + CW'(exe_acc) - CW'(deq);
    end

    // FIFO state: storage, pointers and count, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (mem_acc) begin
                slot_q[tail_q] <= '{rd: memRd, data: memData};
            end
            if (exe_acc) begin
                slot_q[exe_slot] <= '{rd: exeRd, data: exeResult};
            end
        end
    end

    // Retire port: head goes to the register file, or to the PC if it targets R15.
    always_comb begin
        head_entry = slot_q[head_q];
        head_is_pc = (head_entry.rd == PC_REG);
        regWrite   = deq && !head_is_pc;
        pcWrite    = deq && head_is_pc;
        A3         = regWrite ? head_entry.rd   : 4'd0;
        WD3        = regWrite ? head_entry.data : '0;
        pcTarget   = pcWrite  ? head_entry.data : '0;
    end

    // Scan stored entries oldest to youngest so the youngest match wins.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        look_idx = head_q;
`ifdef WB_BYPASS_EN
        fwd1     = '0;
        fwd2     = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            look_idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((A1 != PC_REG) && (slot_q[look_idx].rd == A1)) begin
                    hit1 = 1'b1;
`ifdef WB_BYPASS_EN
                    fwd1 = slot_q[look_idx].data;
`endif
                end
                if ((A2 != PC_REG) && (slot_q[look_idx].rd == A2)) begin
                    hit2 = 1'b1;
`ifdef WB_BYPASS_EN
                    fwd2 = slot_q[look_idx].data;
`endif
                end
            end
        end
    end

    // Decode-facing result: forward when bypass is built in, otherwise stall.
    always_comb begin
`ifdef WB_BYPASS_EN
        hazA1      = 1'b0;
        hazA2      = 1'b0;
        fwdA1Valid = hit1;
        fwdA2Valid = hit2;
        fwdA1Data  = fwd1;
        fwdA2Data  = fwd2;
`else
        hazA1      = hit1;
        hazA2      = hit2;
        fwdA1Valid = 1'b0;
        fwdA2Valid = 1'b0;
        fwdA1Data  = '0;
        fwdA2Data  = '0;
`endif
    end

    assign count = count_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
`timescale 1ns/1ps
// Directed self-checking bench for wb_commit_unit (DEPTH=4, N=32).
module tb_wb_commit_unit;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          exeValid, memValid;
    logic [3:0]    exeRd, memRd;
    logic [N-1:0]  exeResult, memData;
    logic          exeReady, memReady;
    logic          regWrite, pcWrite;
    logic [3:0]    A3, A1, A2;
    logic [N-1:0]  WD3, pcTarget;
    logic          hazA1, hazA2, fwdA1Valid, fwdA2Valid;
    logic [N-1:0]  fwdA1Data, fwdA2Data;
    logic [2:0]    count;

    int            checks   = 0;
    int            failures = 0;

    logic [35:0]   q[$];
    int            m_cnt, nxt, retired, e;
    bit            mv, ev, mem_acc, exe_acc;

    always #5 clk = ~clk;

    wb_commit_unit #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .exeValid(exeValid), .exeRd(exeRd), .exeResult(exeResult), .exeReady(exeReady),
        .memValid(memValid), .memRd(memRd), .memData(memData), .memReady(memReady),
        .regWrite(regWrite), .A3(A3), .WD3(WD3),
        .pcWrite(pcWrite), .pcTarget(pcTarget),
        .A1(A1), .A2(A2),
        .hazA1(hazA1), .hazA2(hazA2),
        .fwdA1Valid(fwdA1Valid), .fwdA2Valid(fwdA2Valid),
        .fwdA1Data(fwdA1Data), .fwdA2Data(fwdA2Data),
        .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        exeValid = 1'b0; exeRd = '0; exeResult = '0;
        memValid = 1'b0; memRd = '0; memData = '0;
        A1 = 4'd0; A2 = 4'd0;

        // Reset state
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_regWrite", regWrite, 0);
        check("rst_pcWrite", pcWrite, 0);
        check("rst_memReady", memReady, 0);
        check("rst_exeReady", exeReady, 0);
        reset = 1'b0;
        #1;
        check("rel_memReady", memReady, 1);
        check("rel_exeReady", exeReady, 1);

        // Single exe into empty FIFO
        exeValid = 1'b1; exeRd = 4'd4; exeResult = 32'h0000_00AA;
        tick();
        exeValid = 1'b0;
        check("one_regWrite", regWrite, 1);
        check("one_A3", A3, 4);
        check("one_WD3", WD3, 32'hAA);
        check("one_count", count, 1);
        tick();
        check("one_regWrite_after", regWrite, 0);
        check("one_count_after", count, 0);

        // Same-edge mem then exe: mem is older
        memValid = 1'b1; memRd = 4'd2; memData = 32'h11;
        exeValid = 1'b1; exeRd = 4'd3; exeResult = 32'h22;
        tick();
        memValid = 1'b0; exeValid = 1'b0;
        check("pair_count0", count, 2);
        check("pair_A3_0", A3, 2);
        check("pair_WD3_0", WD3, 32'h11);
        tick();
        check("pair_count1", count, 1);
        check("pair_A3_1", A3, 3);
        check("pair_WD3_1", WD3, 32'h22);
        tick();
        check("pair_count2", count, 0);
        check("pair_regWrite2", regWrite, 0);

        // R15 write becomes a one-cycle PC redirect, never hazarded
        exeValid = 1'b1; exeRd = 4'd15; exeResult = 32'h100; A1 = 4'd15;
        tick();
        exeValid = 1'b0;
        check("pc_pcWrite", pcWrite, 1);
        check("pc_pcTarget", pcTarget, 32'h100);
        check("pc_regWrite", regWrite, 0);
        check("pc_hazA1", hazA1, 0);
        check("pc_fwdA1Valid", fwdA1Valid, 0);
        tick();
        check("pc_pcWrite_after", pcWrite, 0);
        check("pc_pcTarget_after", pcTarget, 0);

        // Hazard / forwarding with two pending writes to R5
        memValid = 1'b1; memRd = 4'd5; memData = 32'h7;
        exeValid = 1'b1; exeRd = 4'd5; exeResult = 32'h9;
        A1 = 4'd5; A2 = 4'd6;
        #1;
        check("haz_offered_only", hazA1, 0);
        check("fwd_offered_only", fwdA1Valid, 0);
        tick();
        memValid = 1'b0; exeValid = 1'b0;
        check("haz_count", count, 2);
        check("haz_hazA2", hazA2, 0);
        check("haz_fwdA2Valid", fwdA2Valid, 0);
`ifdef WB_BYPASS_EN
        check("haz_hazA1", hazA1, 0);
        check("haz_fwdA1Valid", fwdA1Valid, 1);
        check("haz_fwdA1Data", fwdA1Data, 32'h9);
`else
        check("haz_hazA1", hazA1, 1);
        check("haz_fwdA1Valid", fwdA1Valid, 0);
        check("haz_fwdA1Data", fwdA1Data, 0);
`endif
        tick();
`ifdef WB_BYPASS_EN
        check("haz1_fwdA1Data", fwdA1Data, 32'h9);
`else
        check("haz1_hazA1", hazA1, 1);
`endif
        tick();
        check("haz2_hazA1", hazA1, 0);
        check("haz2_fwdA1Valid", fwdA1Valid, 0);
        A1 = 4'd0; A2 = 4'd0;

        // Continuous streaming of 20 ordered values across pointer wrap
        m_cnt = 0; nxt = 0; retired = 0;
        for (int cyc = 0; cyc < 80 && retired < 20; cyc++) begin
            check("s_count", count, 64'(m_cnt));
            check("s_memReady", memReady, 64'(m_cnt <= 3));
            check("s_exeReady", exeReady, 64'(m_cnt <= 2));
            if (q.size() != 0) begin
                check("s_regWrite", regWrite, 1);
                check("s_A3", A3, 64'(q[0][35:32]));
                check("s_WD3", WD3, 64'(q[0][31:0]));
            end else begin
                check("s_regWrite_idle", regWrite, 0);
            end
            mv      = (nxt < 20);
            mem_acc = mv && (m_cnt <= 3);
            e       = nxt + int'(mem_acc);
            ev      = (e < 20);
            exe_acc = ev && (m_cnt <= 2);
            memValid = mv; memRd = 4'(1 + nxt % 14); memData = 32'(nxt + 256);
            exeValid = ev; exeRd = 4'(1 + e % 14);   exeResult = 32'(e + 256);
            tick();
            if (q.size() != 0) begin
                void'(q.pop_front());
                retired++;
            end
            if (mem_acc) q.push_back({4'(1 + nxt % 14), 32'(nxt + 256)});
            if (exe_acc) q.push_back({4'(1 + e % 14), 32'(e + 256)});
            nxt   = nxt + int'(mem_acc) + int'(exe_acc);
            m_cnt = q.size();
        end
        memValid = 1'b0; exeValid = 1'b0;
        check("s_retired", 64'(retired), 20);
        check("s_count_end", count, 0);

        // Asynchronous reset mid-stream with three entries queued
        memValid = 1'b1; memRd = 4'd1; memData = 32'hA;
        exeValid = 1'b1; exeRd = 4'd2; exeResult = 32'hB;
        tick();
        memRd = 4'd3; memData = 32'hC;
        exeRd = 4'd4; exeResult = 32'hD;
        tick();
        memValid = 1'b0; exeValid = 1'b0;
        check("mid_count_pre", count, 3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_count", count, 0);
        check("mid_regWrite", regWrite, 0);
        check("mid_memReady", memReady, 0);
        check("mid_exeReady", exeReady, 0);
        tick();
        check("mid_count_hold", count, 0);
        reset = 1'b0;
        #1;
        check("mid_rel_memReady", memReady, 1);
        check("mid_rel_exeReady", exeReady, 1);
        tick();
        check("mid_post_regWrite", regWrite, 0);
        check("mid_post_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
